tetris_pixel_compositor: RTL and testbench

TETRIS_PIXEL_COMPOSITOR -- requirements
Module: tetris_pixel_compositor

---
 rtl/tetris_pixel_compositor.sv | 199 +++++++++++++++++++
 tb/tb_tetris_pixel_compositor.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/tetris_pixel_compositor.sv
// Tetris pixel compositor: two-stage colour pipeline with per-player
// line-clear flash and game-over dimming effects.

module tetris_player_fsm #(
    parameter int FLASH_FRAMES = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic frame_start_i,
    input  logic line_clear_i,
    input  logic game_over_i,
    output logic flash_o,
    output logic flash_on_o,
    output logic dim_o
);
    typedef enum logic [1:0] {IDLE, FLASH, DIM} state_e;

    state_e     state_q, state_d;
    logic [7:0] fcnt_q, fcnt_d;
    logic       flash_q;

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            IDLE: begin
                if (game_over_i) begin
                    state_d = DIM;
                end else if (line_clear_i) begin
                    state_d = FLASH;
                    fcnt_d  = 8'd0;
                end
            end
            FLASH: begin
                // line_clear wins over a coincident frame_start
                if (game_over_i) begin
                    state_d = DIM;
                    fcnt_d  = 8'd0;
                end else if (line_clear_i) begin
                    fcnt_d = 8'd0;
                end else if (frame_start_i) begin
                    if (fcnt_q == 8'(FLASH_FRAMES - 1)) begin
                        state_d = IDLE;
                        fcnt_d  = 8'd0;
                    end else begin
                        fcnt_d = fcnt_q + 8'd1;
                    end
                end
            end
            DIM: begin
                if (!game_over_i) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                fcnt_d  = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            fcnt_q  <= 8'd0;
            flash_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            flash_q <= (state_d == FLASH);
        end
    end

    assign flash_o    = flash_q;
    assign flash_on_o = (state_q == FLASH) && !fcnt_q[0];
    assign dim_o      = (state_q == DIM);
endmodule

module tetris_pixel_compositor #(
    parameter  int NUM_PLAYERS  = 2,
    parameter  int COLOR_W      = 8,
    parameter  int FLASH_FRAMES = 8,
    localparam int PS_W         = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   frame_start,
    input  logic                   pix_valid_in,
    input  logic [9:0]             DrawX,
    input  logic [9:0]             DrawY,
    input  logic [PS_W-1:0]        player_sel,
    input  logic                   play_hit,
    input  logic                   font_hit,
    input  logic                   sprite_hit,
    input  logic [3*COLOR_W-1:0]   sprite_rgb,
    input  logic [NUM_PLAYERS-1:0] line_clear,
    input  logic [NUM_PLAYERS-1:0] game_over,
    output logic [COLOR_W-1:0]     VGA_R,
    output logic [COLOR_W-1:0]     VGA_G,
    output logic [COLOR_W-1:0]     VGA_B,
    output logic                   pix_valid_out,
    output logic [NUM_PLAYERS-1:0] flashing
);
    logic [NUM_PLAYERS-1:0] flash_on, dim;

    for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_pl
        tetris_player_fsm #(.FLASH_FRAMES(FLASH_FRAMES)) u_fsm (
            .clk_i        (Clk),
            .rst_ni       (Reset_n),
            .frame_start_i(frame_start),
            .line_clear_i (line_clear[i]),
            .game_over_i  (game_over[i]),
            .flash_o      (flashing[i]),
            .flash_on_o   (flash_on[i]),
            .dim_o        (dim[i])
        );
    end

    // Out-of-range player_sel matches no player, so no effect applies
    logic sel_flash, sel_dim;
    always_comb begin
        sel_flash = 1'b0;
        sel_dim   = 1'b0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (player_sel == PS_W'(i)) begin
                sel_flash = flash_on[i];
                sel_dim   = dim[i];
            end
        end
    end

    logic [1:0]           vld_pipe_q;
    logic                 s1_play_q, s1_font_q, s1_spr_q, s1_flash_q, s1_dim_q;
    logic [3*COLOR_W-1:0] s1_rgb_q;
    logic [6:0]           s1_bgx_q;
    logic [COLOR_W-1:0]   out_r_q, out_g_q, out_b_q;
    logic [COLOR_W-1:0]   out_r_d, out_g_d, out_b_d;

    logic [COLOR_W-1:0] bg_r, bg_b;
    assign bg_r = COLOR_W'(8'h1F) << (COLOR_W - 8);
    assign bg_b = COLOR_W'(8'h7F - {1'b0, s1_bgx_q}) << (COLOR_W - 8);

    always_comb begin
        out_r_d = bg_r;
        out_g_d = '0;
        out_b_d = bg_b;
        if (s1_play_q) begin
            {out_r_d, out_g_d, out_b_d} = s1_flash_q ? {3*COLOR_W{1'b1}} : s1_rgb_q;
        end else if (s1_font_q) begin
            {out_r_d, out_g_d, out_b_d} = {3*COLOR_W{1'b1}};
        end else if (s1_spr_q) begin
            {out_r_d, out_g_d, out_b_d} = s1_rgb_q;
        end
        if (s1_dim_q && (s1_play_q || s1_font_q || s1_spr_q)) begin
            out_r_d = out_r_d >> 1;
            out_g_d = out_g_d >> 1;
            out_b_d = out_b_d >> 1;
        end
        if (!vld_pipe_q[0]) begin
            out_r_d = '0;
            out_g_d = '0;
            out_b_d = '0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            vld_pipe_q <= '0;
            s1_play_q  <= 1'b0;
            s1_font_q  <= 1'b0;
            s1_spr_q   <= 1'b0;
            s1_flash_q <= 1'b0;
            s1_dim_q   <= 1'b0;
            s1_rgb_q   <= '0;
            s1_bgx_q   <= '0;
            out_r_q    <= '0;
            out_g_q    <= '0;
            out_b_q    <= '0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[0], pix_valid_in};
            s1_play_q  <= play_hit;
            s1_font_q  <= font_hit;
            s1_spr_q   <= sprite_hit;
            s1_flash_q <= sel_flash;
            s1_dim_q   <= sel_dim;
            s1_rgb_q   <= sprite_rgb;
            s1_bgx_q   <= DrawX[9:3];
            out_r_q    <= out_r_d;
            out_g_q    <= out_g_d;
            out_b_q    <= out_b_d;
        end
    end

    logic unused_ok;
    assign unused_ok = ^{DrawY, DrawX[2:0]};

    assign VGA_R         = out_r_q;
    assign VGA_G         = out_g_q;
    assign VGA_B         = out_b_q;
    assign pix_valid_out = vld_pipe_q[1];
endmodule

// File: tb/tb_tetris_pixel_compositor.sv
// Directed bench for tetris_pixel_compositor with hand-computed expectations.

module tb_tetris_pixel_compositor;
    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       frame_start = 1'b0;
    logic       pix_valid_in = 1'b0;
    logic [9:0] DrawX = '0;
    logic [9:0] DrawY = '0;
    logic [0:0] player_sel = '0;
    logic       play_hit = 1'b0;
    logic       font_hit = 1'b0;
    logic       sprite_hit = 1'b0;
    logic [23:0] sprite_rgb = '0;
    logic [1:0] line_clear = '0;
    logic [1:0] game_over = '0;
    logic [7:0] VGA_R, VGA_G, VGA_B;
    logic       pix_valid_out;
    logic [1:0] flashing;

    int checks = 0;
    int failures = 0;

    tetris_pixel_compositor dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start),
        .pix_valid_in(pix_valid_in), .DrawX(DrawX), .DrawY(DrawY),
        .player_sel(player_sel), .play_hit(play_hit), .font_hit(font_hit),
        .sprite_hit(sprite_hit), .sprite_rgb(sprite_rgb),
        .line_clear(line_clear), .game_over(game_over),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .pix_valid_out(pix_valid_out), .flashing(flashing)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    // One valid pixel, then wait until it reaches the outputs
    task automatic pix(input logic sel, input logic play, input logic font, input logic spr,
                       input logic [23:0] rgb, input logic [9:0] x);
        pix_valid_in = 1'b1; player_sel = sel; play_hit = play; font_hit = font;
        sprite_hit = spr; sprite_rgb = rgb; DrawX = x;
        tick;
        pix_valid_in = 1'b0; play_hit = 1'b0; font_hit = 1'b0; sprite_hit = 1'b0;
        tick;
    endtask

    task automatic frame;
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
    endtask

    task automatic lc(input int p);
        line_clear[p] = 1'b1;
        tick;
        line_clear = '0;
    endtask

    function automatic logic [31:0] col();
        return {8'h00, VGA_R, VGA_G, VGA_B};
    endfunction

    initial begin
        Reset_n = 1'b1;
        #1 Reset_n = 1'b0;
        #1;
        chk("rst_col", col(), 32'h0);
        chk("rst_vld", {31'b0, pix_valid_out}, 32'd0);
        chk("rst_flash", {30'b0, flashing}, 32'd0);
        tick; tick;
        Reset_n = 1'b1;

        // latency
        pix_valid_in = 1'b1; play_hit = 1'b1; sprite_rgb = 24'h0058F8;
        tick;
        pix_valid_in = 1'b0; play_hit = 1'b0;
        chk("lat_c1_col", col(), 32'h0);
        chk("lat_c1_vld", {31'b0, pix_valid_out}, 32'd0);
        tick;
        chk("lat_c2_col", col(), 32'h0058F8);
        chk("lat_c2_vld", {31'b0, pix_valid_out}, 32'd1);
        tick;
        chk("lat_c3_col", col(), 32'h0);
        chk("lat_c3_vld", {31'b0, pix_valid_out}, 32'd0);

        // priority
        pix(1'b0, 1'b1, 1'b1, 1'b0, 24'h0058F8, 10'd0);
        chk("pri_play_font", col(), 32'h0058F8);
        pix(1'b0, 1'b0, 1'b1, 1'b1, 24'h0058F8, 10'd0);
        chk("pri_font_spr", col(), 32'hFFFFFF);
        pix(1'b0, 1'b0, 1'b0, 1'b1, 24'h123456, 10'd0);
        chk("pri_spr", col(), 32'h123456);
        pix(1'b0, 1'b0, 1'b0, 1'b0, 24'h123456, 10'd80);
        chk("pri_bg80", col(), 32'h1F0075);
        pix(1'b0, 1'b0, 1'b0, 1'b0, 24'h123456, 10'd639);
        chk("pri_bg639", col(), 32'h1F0030);

        // flash on player 1
        lc(1);
        for (int k = 0; k < 8; k++) begin
            pix(1'b1, 1'b1, 1'b0, 1'b0, 24'h0058F8, 10'd0);
            chk($sformatf("flash_col_f%0d", k), col(), (k % 2 == 0) ? 32'hFFFFFF : 32'h0058F8);
            chk($sformatf("flash_hi_f%0d", k), {31'b0, flashing[1]}, 32'd1);
            frame;
        end
        chk("flash_end", {30'b0, flashing}, 32'd0);
        pix(1'b1, 1'b1, 1'b0, 1'b0, 24'h0058F8, 10'd0);
        chk("flash_idle_col", col(), 32'h0058F8);

        // retrigger and simultaneity on player 0
        lc(0);
        for (int k = 0; k < 5; k++) frame;
        pix(1'b0, 1'b1, 1'b0, 1'b0, 24'hA0B0C0, 10'd0);
        chk("rt_f5_col", col(), 32'hA0B0C0);
        lc(0);
        pix(1'b0, 1'b1, 1'b0, 1'b0, 24'hA0B0C0, 10'd0);
        chk("rt_f0_col", col(), 32'hFFFFFF);
        frame; frame;
        line_clear[0] = 1'b1; frame_start = 1'b1;
        tick;
        line_clear = '0; frame_start = 1'b0;
        pix(1'b0, 1'b1, 1'b0, 1'b0, 24'hA0B0C0, 10'd0);
        chk("sim_f0_col", col(), 32'hFFFFFF);
        frame;
        pix(1'b0, 1'b1, 1'b0, 1'b0, 24'hA0B0C0, 10'd0);
        chk("sim_f1_col", col(), 32'hA0B0C0);
        pix(1'b1, 1'b1, 1'b0, 1'b0, 24'hA0B0C0, 10'd0);
        chk("p1_unaff_col", col(), 32'hA0B0C0);
        chk("p1_unaff_fl", {31'b0, flashing[1]}, 32'd0);
        for (int k = 0; k < 6; k++) frame;
        chk("rt_still", {30'b0, flashing}, 32'd1);
        frame;
        chk("rt_done", {30'b0, flashing}, 32'd0);

        // game over
        lc(0);
        chk("go_flash", {31'b0, flashing[0]}, 32'd1);
        game_over[0] = 1'b1;
        tick;
        chk("go_dim_fl", {31'b0, flashing[0]}, 32'd0);
        pix(1'b0, 1'b1, 1'b0, 1'b0, 24'hF0BC3C, 10'd0);
        chk("go_dim_play", col(), 32'h785E1E);
        pix(1'b0, 1'b0, 1'b0, 1'b0, 24'hF0BC3C, 10'd80);
        chk("go_dim_bg", col(), 32'h1F0075);
        pix(1'b0, 1'b0, 1'b1, 1'b0, 24'hF0BC3C, 10'd0);
        chk("go_dim_font", col(), 32'h7F7F7F);
        pix(1'b1, 1'b1, 1'b0, 1'b0, 24'hF0BC3C, 10'd0);
        chk("go_p1_play", col(), 32'hF0BC3C);
        lc(0);
        chk("go_lc_ign", {31'b0, flashing[0]}, 32'd0);
        game_over[0] = 1'b0;
        tick;
        chk("go_idle_fl", {30'b0, flashing}, 32'd0);
        pix(1'b0, 1'b1, 1'b0, 1'b0, 24'hF0BC3C, 10'd0);
        chk("go_idle_play", col(), 32'hF0BC3C);

        // reset mid-flash with pixels in flight
        lc(1);
        pix_valid_in = 1'b1; player_sel = 1'b1; play_hit = 1'b1; sprite_rgb = 24'h123456;
        tick; tick;
        chk("rf_pre_col", col(), 32'hFFFFFF);
        chk("rf_pre_vld", {31'b0, pix_valid_out}, 32'd1);
        #2 Reset_n = 1'b0;
        #1;
        chk("rf_async_col", col(), 32'h0);
        chk("rf_async_vld", {31'b0, pix_valid_out}, 32'd0);
        chk("rf_async_fl", {30'b0, flashing}, 32'd0);
        tick;
        chk("rf_hold_col", col(), 32'h0);
        Reset_n = 1'b1;
        tick;
        chk("rf_rel_vld", {31'b0, pix_valid_out}, 32'd0);
        chk("rf_rel_fl", {30'b0, flashing}, 32'd0);
        pix_valid_in = 1'b0; play_hit = 1'b0;
        tick;
        chk("rf_first_vld", {31'b0, pix_valid_out}, 32'd1);
        chk("rf_first_col", col(), 32'h123456);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
